adder_cout_pipe: RTL and testbench
==================================

Name: adder_cout_pipe

Overview:
Parametrised, pipelined N-bit add/subtract unit with carry-in, carry-out and signed overflow. Generalises the single-bit, purely combinational carry-out adder to N bits. The carry chain is split into STAGES registered slices so wide adders close timing on the iCE40 carry chain. It sits between operand sources (counters, UART byte paths) and result consumers, with a valid strobe travelling alongside the data.

Parameters:
N, 8, operand/result width in bits; N >= 1.
STAGES, 2, number of pipeline slices; 1 <= STAGES <= N; N % STAGES == 0 (elaboration error otherwise).
W (derived), N/STAGES, bits per slice; not overridable.

Ports:
CLKIN  input  1  system clock, rising-edge.
RESET  input  1  synchronous, active-high reset.
VALID_IN  input  1  operands/controls valid this cycle.
I0  input  N  operand A.
I1  input  N  operand B.
CIN  input  1  carry-in (add) / borrow-in (sub).
SUB  input  1  0 = A+B+CIN; 1 = A-B-CIN.
O  output  N  result, registered.
COUT  output  1  carry-out of MSB (sub: 1 = no borrow).
OVF  output  1  two's-complement overflow.
VALID_OUT  output  1  O/COUT/OVF carry a new result this cycle.

Behaviour:
- Interface: one clock, CLKIN; RESET synchronous, active-high, sampled on the CLKIN rising edge.
- Effective operation: B' = SUB ? ~I1 : I1; c0 = CIN ^ SUB. Sum = I0 + B' + c0, computed modulo 2^N.
- Slicing: slice k, for k = 0..STAGES-1, covers bits [k*W +: W].
- Operand skew: slice k consumes I0/B' bits delayed k cycles via skew registers. SUB is folded into B' and c0 at the input, so it is not re-sampled downstream.
- Each slice is a ripple full-adder chain (sum = a^b^c, carry = maj(a,b,c)). Its carry-out is registered and feeds slice k+1 on the next cycle.
- Output deskew: sum slice k is delayed STAGES-1-k cycles so all N bits align.
- Latency: exactly STAGES cycles. An operation sampled with VALID_IN=1 at edge t produces VALID_OUT=1 and its result in the cycle following edge t+STAGES-1. STAGES=1 gives a registered adder with latency 1.
- Throughput: one operation per cycle. There is no backpressure and no stall input; results emerge in issue order.
- Valid tracking: VALID_IN is shifted through a STAGES-deep valid pipe; VALID_OUT is its last stage.
- Output hold: O, COUT and OVF update only on cycles where the emerging slot is valid. Otherwise they hold the last valid result. Internal data registers may load don't-care values for invalid slots.
- COUT = carry out of bit N-1.
- OVF = carry into bit N-1 XOR carry out of bit N-1. For N=1, the carry into bit 0 is c0.
- Reset values: O=0, COUT=0, OVF=0, VALID_OUT=0; all valid-pipe bits, carry registers and skew/deskew registers = 0.
- Reset mid-operation: all in-flight operations are discarded; none ever produce VALID_OUT.
- Reset and VALID_IN high on the same edge: reset wins and the operation is dropped. The first operation accepted is on the edge after RESET deasserts.
- Bubbles: a VALID_IN=0 cycle between operations produces a VALID_OUT=0 cycle at the same relative position; outputs hold through it.
- Operand or control changes during a non-valid cycle have no effect on outputs.

Test Plan:
- N=8, STAGES=2: I0=0xFF, I1=0x01, CIN=0, SUB=0, one valid cycle -> 2 cycles later VALID_OUT=1, O=0x00, COUT=1, OVF=0; next cycle VALID_OUT=0, outputs held.
- Subtract with borrow: I0=0x05, I1=0x07, SUB=1, CIN=0 -> O=0xFE, COUT=0, OVF=0. Then I0=0x80, I1=0x01, SUB=1 -> O=0x7F, COUT=1, OVF=1.
- Signed overflow and carry-in: I0=0x7F, I1=0x00, CIN=1, SUB=0 -> O=0x80, COUT=0, OVF=1.
- Streaming with a bubble: valid ops (1+2), (3+4), bubble, (0xF0+0x20) on consecutive cycles -> VALID_OUT pattern 1,1,0,1 starting at latency 2; O = 0x03, 0x07, hold 0x07, 0x10 with COUT=1 on the last.
- Reset mid-flight: issue two valid ops, assert RESET for 1 cycle at the edge after the second -> VALID_OUT never asserts for either; O/COUT/OVF=0. The next op after reset returns the correct result at latency 2.
- Parameter sweep (N=1/STAGES=1, N=16/STAGES=4, N=12/STAGES=3): random operands, SUB and CIN vs. a reference model -> O/COUT/OVF match every result, with latency exactly STAGES.

Source files
------------

// File: rtl/adder_cout_pipe.sv
// adder_cout_pipe: pipelined N-bit add/subtract with carry-in, carry-out and signed overflow.
// The carry chain is cut into STAGES registered slices; operands are skewed in and sums deskewed out.
module adder_cout_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         CLKIN,
    input  logic         RESET,
    input  logic         VALID_IN,
    input  logic [N-1:0] I0,
    input  logic [N-1:0] I1,
    input  logic         CIN,
    input  logic         SUB,
    output logic [N-1:0] O,
    output logic         COUT,
    output logic         OVF,
    output logic         VALID_OUT
);
    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || N % STAGES != 0) begin : g_bad_params
        $error("adder_cout_pipe: STAGES must divide N with 1 <= STAGES <= N");
    end

    logic [N-1:0]    b_eff;
    logic            c0;
    logic [N-1:0]    sum_al;
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0] vld_ext;
    logic [N-1:0]    o_q;
    logic            cout_q;
    logic            ovf_q;
    logic            msb_cin;
    logic            ovf_d;

    assign b_eff   = SUB ? ~I1 : I1;
    assign c0      = CIN ^ SUB;
    assign vld_ext = {vld_q, VALID_IN};

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int D = STAGES - 1 - k;
        logic [W-1:0] a_s;
        logic [W-1:0] b_s;
        logic [W-1:0] s_s;
        logic [W-1:0] s_al;
        logic         c_s;
        logic         co;
        if (k == 0) begin : g_in
            assign a_s = I0[W-1:0];
            assign b_s = b_eff[W-1:0];
            assign c_s = c0;
        end else begin : g_skew
            logic [W-1:0] a_q [k];
            logic [W-1:0] b_q [k];
            logic         c_q;
            always_ff @(posedge CLKIN) begin
                if (RESET) begin
                    for (int i = 0; i < k; i++) begin
                        a_q[i] <= '0;
                        b_q[i] <= '0;
                    end
                    c_q <= 1'b0;
                end else begin
                    a_q[0] <= I0[k*W +: W];
                    b_q[0] <= b_eff[k*W +: W];
                    for (int i = 1; i < k; i++) begin
                        a_q[i] <= a_q[i-1];
                        b_q[i] <= b_q[i-1];
                    end
                    c_q <= g_slice[k-1].co;
                end
            end
            assign a_s = a_q[k-1];
            assign b_s = b_q[k-1];
            assign c_s = c_q;
        end
        assign {co, s_s} = {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, c_s};
        if (D == 0) begin : g_nodesk
            assign s_al = s_s;
        end else begin : g_desk
            logic [W-1:0] ds_q [D];
            always_ff @(posedge CLKIN) begin
                if (RESET) begin
                    for (int i = 0; i < D; i++) ds_q[i] <= '0;
                end else begin
                    ds_q[0] <= s_s;
                    for (int i = 1; i < D; i++) ds_q[i] <= ds_q[i-1];
                end
            end
            assign s_al = ds_q[D-1];
        end
        assign sum_al[k*W +: W] = s_al;
    end

    // Carry into the MSB recovered from the MSB's own sum bit and operands.
    assign msb_cin = g_slice[STAGES-1].s_s[W-1] ^ g_slice[STAGES-1].a_s[W-1] ^ g_slice[STAGES-1].b_s[W-1];
    assign ovf_d   = msb_cin ^ g_slice[STAGES-1].co;

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            vld_q  <= '0;
            o_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q <= vld_ext[STAGES-1:0];
            if (vld_ext[STAGES-1]) begin
                o_q    <= sum_al;
                cout_q <= g_slice[STAGES-1].co;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign O         = o_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign VALID_OUT = vld_ext[STAGES];
endmodule

// File: tb/tb_adder_cout_pipe.sv
// tb_adder_cout_pipe: directed checks on the 8-bit/2-stage unit plus randomized
// sweeps of three other geometries against an arithmetic reference model.
module tb_adder_cout_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        v8 = 0, ci8 = 0, s8 = 0;
    logic [7:0]  a8 = 0, b8 = 0, o8;
    logic        co8, ov8, vo8;
    logic        v1 = 0, ci1 = 0, s1 = 0;
    logic [0:0]  a1 = 0, b1 = 0, o1;
    logic        co1, ov1, vo1;
    logic        v16 = 0, ci16 = 0, s16 = 0;
    logic [15:0] a16 = 0, b16 = 0, o16;
    logic        co16, ov16, vo16;
    logic        v12 = 0, ci12 = 0, s12 = 0;
    logic [11:0] a12 = 0, b12 = 0, o12;
    logic        co12, ov12, vo12;

    adder_cout_pipe #(.N(8), .STAGES(2)) u8 (.CLKIN(clk), .RESET(rst), .VALID_IN(v8), .I0(a8), .I1(b8),
        .CIN(ci8), .SUB(s8), .O(o8), .COUT(co8), .OVF(ov8), .VALID_OUT(vo8));
    adder_cout_pipe #(.N(1), .STAGES(1)) u1 (.CLKIN(clk), .RESET(rst), .VALID_IN(v1), .I0(a1), .I1(b1),
        .CIN(ci1), .SUB(s1), .O(o1), .COUT(co1), .OVF(ov1), .VALID_OUT(vo1));
    adder_cout_pipe #(.N(16), .STAGES(4)) u16 (.CLKIN(clk), .RESET(rst), .VALID_IN(v16), .I0(a16), .I1(b16),
        .CIN(ci16), .SUB(s16), .O(o16), .COUT(co16), .OVF(ov16), .VALID_OUT(vo16));
    adder_cout_pipe #(.N(12), .STAGES(3)) u12 (.CLKIN(clk), .RESET(rst), .VALID_IN(v12), .I0(a12), .I1(b12),
        .CIN(ci12), .SUB(s12), .O(o12), .COUT(co12), .OVF(ov12), .VALID_OUT(vo12));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect8(input string tag, input logic v, input logic [7:0] o, input logic c, input logic ov);
        chk({tag, "_valid"}, 32'(vo8), 32'(v));
        chk({tag, "_o"}, 32'(o8), 32'(o));
        chk({tag, "_cout"}, 32'(co8), 32'(c));
        chk({tag, "_ovf"}, 32'(ov8), 32'(ov));
    endtask

    task automatic op8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s);
        v8 = v; a8 = a; b8 = b; ci8 = ci; s8 = s;
    endtask

    // Result as {cout, ovf, o[15:0]} from plain integer arithmetic on n-bit operands.
    function automatic logic [17:0] ref_op(input int n, input int a, input int b, input bit cin, input bit sub);
        int m  = 1 << n;
        int h  = 1 << (n - 1);
        int sa = (a >= h) ? a - m : a;
        int sb = (b >= h) ? b - m : b;
        int r  = sub ? a - b - int'(cin) : a + b + int'(cin);
        int sr = sub ? sa - sb - int'(cin) : sa + sb + int'(cin);
        logic c  = sub ? (r >= 0) : (r >= m);
        logic ov = (sr < -h) || (sr >= h);
        logic [15:0] o = 16'(r & (m - 1));
        return {c, ov, o};
    endfunction

    logic        hv1 [200], hv16 [200], hv12 [200];
    logic [17:0] hr1 [200], hr16 [200], hr12 [200];
    logic [17:0] last1 = '0, last16 = '0, last12 = '0;

    initial begin
        op8(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        cyc();
        cyc();
        expect8("reset_state", 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        op8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc();
        chk("reset_drop_a", 32'(vo8), 0);
        cyc();
        chk("reset_drop_b", 32'(vo8), 0);

        op8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        cyc();
        op8(1'b0, 8'hA5, 8'h5A, 1'b1, 1'b1);
        chk("wrap_lat1", 32'(vo8), 0);
        cyc();
        expect8("wrap", 1'b1, 8'h00, 1'b1, 1'b0);
        cyc();
        expect8("wrap_hold", 1'b0, 8'h00, 1'b1, 1'b0);

        op8(1'b1, 8'h05, 8'h07, 1'b0, 1'b1);
        cyc();
        op8(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
        cyc();
        expect8("sub_borrow", 1'b1, 8'hFE, 1'b0, 1'b0);
        op8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc();
        expect8("sub_ovf", 1'b1, 8'h7F, 1'b1, 1'b1);
        cyc();
        expect8("sub_hold", 1'b0, 8'h7F, 1'b1, 1'b1);

        op8(1'b1, 8'h7F, 8'h00, 1'b1, 1'b0);
        cyc();
        op8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc();
        expect8("cin_ovf", 1'b1, 8'h80, 1'b0, 1'b1);

        op8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        cyc();
        op8(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
        cyc();
        expect8("stream_0", 1'b1, 8'h03, 1'b0, 1'b0);
        op8(1'b0, 8'hEE, 8'hEE, 1'b1, 1'b0);
        cyc();
        expect8("stream_1", 1'b1, 8'h07, 1'b0, 1'b0);
        op8(1'b1, 8'hF0, 8'h20, 1'b0, 1'b0);
        cyc();
        expect8("stream_bubble", 1'b0, 8'h07, 1'b0, 1'b0);
        op8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc();
        expect8("stream_3", 1'b1, 8'h10, 1'b1, 1'b0);

        op8(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        cyc();
        op8(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        op8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        expect8("midrst_0", 1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        expect8("midrst_1", 1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        expect8("midrst_2", 1'b0, 8'h00, 1'b0, 1'b0);
        op8(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        cyc();
        op8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("postrst_lat1", 32'(vo8), 0);
        cyc();
        expect8("postrst", 1'b1, 8'h46, 1'b0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            v1 = ($urandom_range(3) != 0); a1 = 1'($urandom); b1 = 1'($urandom);
            ci1 = 1'($urandom); s1 = 1'($urandom);
            v16 = ($urandom_range(3) != 0); a16 = 16'($urandom); b16 = 16'($urandom);
            ci16 = 1'($urandom); s16 = 1'($urandom);
            v12 = ($urandom_range(3) != 0); a12 = 12'($urandom); b12 = 12'($urandom);
            ci12 = 1'($urandom); s12 = 1'($urandom);
            if (t % 16 < 3) begin
                a16 = 16'h7FFF; b16 = (t % 2 == 0) ? 16'hFFFF : 16'h0000; a12 = 12'hFFF;
            end
            hv1[t] = v1;   hr1[t] = ref_op(1, int'(a1), int'(b1), ci1, s1);
            hv16[t] = v16; hr16[t] = ref_op(16, int'(a16), int'(b16), ci16, s16);
            hv12[t] = v12; hr12[t] = ref_op(12, int'(a12), int'(b12), ci12, s12);
            cyc();
            if (hv1[t]) last1 = hr1[t];
            chk("sw1_valid", 32'(vo1), 32'(hv1[t]));
            chk("sw1_res", 32'({co1, ov1, 16'(o1)}), 32'(last1));
            if (t >= 3 && hv16[t-3]) last16 = hr16[t-3];
            chk("sw16_valid", 32'(vo16), (t >= 3) ? 32'(hv16[t-3]) : 0);
            chk("sw16_res", 32'({co16, ov16, o16}), 32'(last16));
            if (t >= 2 && hv12[t-2]) last12 = hr12[t-2];
            chk("sw12_valid", 32'(vo12), (t >= 2) ? 32'(hv12[t-2]) : 0);
            chk("sw12_res", 32'({co12, ov12, 4'h0, o12}), 32'(last12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
